// File: rtl/fetch_buffer_unit.sv
// fetch_buffer_unit
//
// Purpose: front-end fetch stage. Holds the fetch PC, issues one
// instruction-cache request per enabled cycle, and buffers returned
// instructions (with their PCs) in a small FIFO that feeds the instruction
// queue. Prioritised redirect channels replace the PC and flush the FIFO.
//
// Ports:
//   clk_in              clock, all state changes on the rising edge
//   rst_in              synchronous active-high reset (wins over rdy_in)
//   rdy_in              global enable; low freezes every register
//   redirect_en_in      per-channel redirect request, channel 0 wins
//   redirect_pc_in      packed redirect targets, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   icache_req_out      registered fetch-request valid
//   icache_addr_out     registered fetch address (the internal PC)
//   icache_miss_in      high = no instruction available for icache_addr_out
//   icache_inst_in      instruction for icache_addr_out when miss is low
//   instqueue_en_out    FIFO head valid toward the instruction queue
//   instqueue_inst_out  head instruction
//   instqueue_pc_out    head PC
//   instqueue_rdy_in    instruction queue accepts the head this cycle
//   buf_count_out       FIFO occupancy
//
// Handshake: a head entry transfers on a rising edge where instqueue_en_out
// and instqueue_rdy_in are both high. instqueue_en_out never depends on
// instqueue_rdy_in, and the head stays stable until it transfers or a
// redirect/reset flushes the FIFO.

module fetch_buffer_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INST_WIDTH  = 32,
    parameter int                    BUF_DEPTH   = 4,
    parameter int                    REDIRECT_CH = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic [REDIRECT_CH-1:0]            redirect_en_in,
    input  logic [REDIRECT_CH*ADDR_WIDTH-1:0] redirect_pc_in,
    output logic                              icache_req_out,
    output logic [ADDR_WIDTH-1:0]             icache_addr_out,
    input  logic                              icache_miss_in,
    input  logic [INST_WIDTH-1:0]             icache_inst_in,
    output logic                              instqueue_en_out,
    output logic [INST_WIDTH-1:0]             instqueue_inst_out,
    output logic [ADDR_WIDTH-1:0]             instqueue_pc_out,
    input  logic                              instqueue_rdy_in,
    output logic [$clog2(BUF_DEPTH):0]        buf_count_out
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] pc;
    logic                  req;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic [INST_WIDTH-1:0] inst_mem [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [BUF_DEPTH];

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  full;
    logic                  pop;
    logic                  push;

    // Scan from the highest channel down so the lowest asserted index is
    // the last writer and therefore wins.
    always_comb begin
        redirect        = 1'b0;
        redirect_target = '0;
        for (int i = REDIRECT_CH - 1; i >= 0; i--) begin
            if (redirect_en_in[i]) begin
                redirect        = 1'b1;
                redirect_target = redirect_pc_in[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign full             = (count == CNT_W'(BUF_DEPTH));
    assign instqueue_en_out = (count != '0) && rdy_in && !redirect;
    assign pop              = instqueue_en_out && instqueue_rdy_in;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push             = rdy_in && !redirect && req && !icache_miss_in
                              && (!full || pop);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc     <= RESET_PC;
            req    <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (rdy_in) begin
            req <= 1'b1;
            if (redirect) begin
                pc     <= redirect_target;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc     <= pc + ADDR_WIDTH'(4);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only observed while count covers them.
    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            inst_mem[wr_ptr] <= icache_inst_in;
            pc_mem[wr_ptr]   <= pc;
        end
    end

    assign icache_req_out     = req;
    assign icache_addr_out    = pc;
    assign instqueue_inst_out = inst_mem[rd_ptr];
    assign instqueue_pc_out   = pc_mem[rd_ptr];
    assign buf_count_out      = count;

endmodule

// File: doc/fetch_buffer_unit.md
FETCH_BUFFER_UNIT -- requirements
Module: fetch_buffer_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning PC/address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32, meaning instruction word width.
REQ-003 SHALL have parameter BUF_DEPTH, default 4, meaning entries in the internal fetch FIFO; power of two, >=2.
REQ-004 SHALL have parameter REDIRECT_CH, default 3, meaning number of redirect channels; channel 0 has highest priority.
REQ-005 SHALL have parameter RESET_PC, default 0, meaning PC after reset.
REQ-006 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-009 SHALL have port redirect_en_in  input  REDIRECT_CH  per-channel redirect request.
REQ-010 SHALL have port redirect_pc_in  input  REDIRECT_CH*ADDR_WIDTH  target PC; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port icache_req_out  output  1  fetch request valid (registered).
REQ-012 SHALL have port icache_addr_out  output  ADDR_WIDTH  fetch address (registered); always equals internal pc.
REQ-013 SHALL have port icache_miss_in  input  1  high = no valid data this cycle for icache_addr_out.
REQ-014 SHALL have port icache_inst_in  input  INST_WIDTH  instruction at icache_addr_out, valid when icache_miss_in low.
REQ-015 SHALL have port instqueue_en_out  output  1  head entry valid toward instruction queue.
REQ-016 SHALL have port instqueue_inst_out  output  INST_WIDTH  head instruction.
REQ-017 SHALL have port instqueue_pc_out  output  ADDR_WIDTH  PC of head instruction.
REQ-018 SHALL have port instqueue_rdy_in  input  1  instruction queue accepts head this cycle.
REQ-019 SHALL have port buf_count_out  output  clog2(BUF_DEPTH)+1  current FIFO occupancy.

Function
REQ-020 SHALL take no action in any cycle where rst_in low and rdy_in low: pc, FIFO, pointers, count, icache_req_out all hold.
REQ-021 SHALL, in a rdy_in cycle, define redirect = OR of redirect_en_in; selected target = redirect_pc_in of lowest-index asserted channel.
REQ-022 SHALL, on redirect, set pc to selected target, empty the FIFO (count 0, pointers 0), discard any icache data that cycle, and set icache_req_out 1.
REQ-023 SHALL drive instqueue_en_out = (count != 0) AND rdy_in AND NOT redirect, combinationally; inst/pc outputs show FIFO head (don't-care when en low).
REQ-024 SHALL pop the head when instqueue_en_out AND instqueue_rdy_in at the clock edge.
REQ-025 SHALL push {icache_inst_in, pc} when rdy_in, no redirect, icache_req_out=1, icache_miss_in=0, and (count < BUF_DEPTH or pop this cycle); then pc <= pc+4, wrapping modulo 2^ADDR_WIDTH.
REQ-026 SHALL hold pc and not push on miss, or when full without simultaneous pop; the same address is retried next cycle.
REQ-027 SHALL update count as count+push-pop, with simultaneous push and pop at full leaving count at BUF_DEPTH; pointers wrap modulo BUF_DEPTH.
REQ-028 SHALL deliver entries in push order; push-to-earliest-en latency is 1 cycle (entry visible the cycle after push).
REQ-029 SHALL set icache_req_out 1 in every rdy_in cycle after reset, and give redirect priority over push, pop and hold.

Reset
REQ-030 SHALL, when rst_in high at a clock edge (regardless of rdy_in), set pc=icache_addr_out=RESET_PC, icache_req_out=0, count=0, pointers=0; instqueue_en_out=0 while count=0; reset mid-operation discards all buffered entries.

Verification
REQ-031 SHALL cover: reset, rdy_in=1, miss=0, instqueue_rdy=1, inst=0x13 -> entries pc 0,4,8 delivered in order, en first high one cycle after first push.
REQ-032 SHALL cover: instqueue_rdy=0 with hits -> count reaches 4, icache_addr_out holds 0x10, no further push; rdy released -> pc 0x0 delivered first, fetch resumes at 0x10.
REQ-033 SHALL cover: count=3, channels 0 and 2 redirect to 0x100/0x200 same cycle -> en=0 that cycle, count=0, icache_addr_out=0x100 next cycle.
REQ-034 SHALL cover: miss=1 for 3 cycles at pc 0x8 -> no push, addr stays 0x8; miss=0 -> entry pc 0x8 pushed, pc becomes 0xC.
REQ-035 SHALL cover: ADDR_WIDTH=32, redirect to 0xFFFFFFFC, hit -> entry pc 0xFFFFFFFC, next pc 0x0.
REQ-036 SHALL cover: rdy_in=0 for 2 cycles with hits and redirects asserted -> no state change; rst_in high mid-stream -> count=0, addr=RESET_PC.
